// File: rtl/debouncer_multi_ch.sv
// rtl/debouncer_multi_ch.sv - N-channel switch debouncer with per-channel synchroniser, dwell counter and FSM.
module debouncer_multi_ch #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 20,
  parameter int PRESS_TICKS   = 500000,
  parameter int RELEASE_TICKS = 500000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_en,
  input  logic            clr,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            busy
);

  if (PRESS_TICKS < 1 || PRESS_TICKS >= 2**CNT_W) begin : g_bad_press
    $error("debouncer_multi_ch: PRESS_TICKS out of range 1..2^CNT_W-1");
  end
  if (RELEASE_TICKS < 1 || RELEASE_TICKS >= 2**CNT_W) begin : g_bad_release
    $error("debouncer_multi_ch: RELEASE_TICKS out of range 1..2^CNT_W-1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debouncer_multi_ch: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TICKS - 1);

  logic [N_CH-1:0] waiting;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   deb_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[i]};
    end
    assign s = sync_q[SYNC_STAGES-1];

    // Terminal count is tested before incrementing, so cnt never wraps.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= LOW;
        cnt    <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (clr) begin
          state  <= LOW;
          cnt    <= '0;
          deb_q  <= 1'b0;
          fall_q <= deb_q;
        end else begin
          case (state)
            LOW: if (s) begin
              state <= WAIT_HIGH;
              cnt   <= '0;
            end
            WAIT_HIGH: begin
              if (!s) state <= LOW;
              else if (tick_en) begin
                if (cnt == PRESS_LAST) begin
                  state  <= HIGH;
                  deb_q  <= 1'b1;
                  rise_q <= 1'b1;
                end else cnt <= cnt + CNT_W'(1);
              end
            end
            HIGH: if (!s) begin
              state <= WAIT_LOW;
              cnt   <= '0;
            end
            WAIT_LOW: begin
              if (s) state <= HIGH;
              else if (tick_en) begin
                if (cnt == RELEASE_LAST) begin
                  state  <= LOW;
                  deb_q  <= 1'b0;
                  fall_q <= 1'b1;
                end else cnt <= cnt + CNT_W'(1);
              end
            end
            default: state <= LOW;
          endcase
        end
      end
    end

    assign debounced[i] = deb_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
    assign waiting[i]   = (state == WAIT_HIGH) || (state == WAIT_LOW);
  end

  assign busy = |waiting;

endmodule

// File: tb/tb_debouncer_multi_ch.sv
// tb/tb_debouncer_multi_ch.sv - Scoreboard bench for debouncer_multi_ch with directed stimulus.
module tb_debouncer_multi_ch;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic       clr;
  logic [1:0] noisy;
  logic [1:0] debounced;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t;

  typedef struct {
    int         cyc;
    logic [1:0] r;
    logic [1:0] f;
    logic [1:0] d;
  } ev_t;

  ev_t q[$];
  ev_t e;

  debouncer_multi_ch #(
    .N_CH(2), .CNT_W(4), .PRESS_TICKS(4), .RELEASE_TICKS(6), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .clr(clr), .noisy(noisy),
    .debounced(debounced), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the next expected event, in cycle and content.
  always @(negedge clk) begin
    if (rise != 2'b00 || fall != 2'b00) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d rise=%b fall=%b deb=%b", cyc, rise, fall, debounced);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.r != rise || e.f != fall || e.d != debounced) begin
          errors++;
          $display("FAIL strobe_event got cyc=%0d rise=%b fall=%b deb=%b exp cyc=%0d rise=%b fall=%b deb=%b",
                   cyc, rise, fall, debounced, e.cyc, e.r, e.f, e.d);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missed_strobe exp cyc=%0d rise=%b fall=%b deb=%b now cyc=%0d", e.cyc, e.r, e.f, e.d, cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic [1:0] r, input logic [1:0] f, input logic [1:0] d);
    ev_t x;
    x.cyc = at; x.r = r; x.f = f; x.d = d;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; tick_en = 1'b1; clr = 1'b0; noisy = 2'b11;

    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("reset_outputs", {debounced, rise, fall, 1'b0, busy}, 8'h00);
    end
    reset = 1'b1;
    expect_ev(cyc + 7, 2'b11, 2'b00, 2'b11);
    step(10);

    noisy = 2'b00;
    expect_ev(cyc + 9, 2'b00, 2'b11, 2'b00);
    step(12);
    noisy = 2'b01;
    expect_ev(cyc + 7, 2'b01, 2'b00, 2'b01);
    step(10);
    noisy = 2'b00;
    expect_ev(cyc + 9, 2'b00, 2'b01, 2'b00);
    step(12);

    repeat (5) begin
      noisy = 2'b01; step(3);
      noisy = 2'b00; step(1);
    end
    step(8);
    chk("bounce_press_rejected", {6'd0, debounced}, 8'h00);
    chk("bounce_press_idle", {7'd0, busy}, 8'h00);

    noisy = 2'b01;
    expect_ev(cyc + 7, 2'b01, 2'b00, 2'b01);
    step(10);
    repeat (5) begin
      noisy = 2'b00; step(1);
      noisy = 2'b01; step(3);
    end
    step(8);
    chk("bounce_release_rejected", {6'd0, debounced}, 8'h01);
    noisy = 2'b00;
    expect_ev(cyc + 9, 2'b00, 2'b01, 2'b00);
    step(12);

    // Ticks land on odd edges after the press, so qualification completes 11 edges later.
    noisy = 2'b01; tick_en = 1'b1;
    expect_ev(cyc + 11, 2'b01, 2'b00, 2'b01);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      tick_en = ~tick_en;
      if (k == 5) chk("busy_wait_high", {7'd0, busy}, 8'h01);
    end
    tick_en = 1'b1;
    step(4);

    noisy = 2'b11;
    t = cyc;
    step(3);
    clr = 1'b1;
    expect_ev(t + 4, 2'b00, 2'b01, 2'b00);
    step(1);
    clr = 1'b0;
    chk("clr_idle", {7'd0, busy}, 8'h00);
    expect_ev(t + 9, 2'b11, 2'b00, 2'b11);
    step(10);

    noisy = 2'b01;
    expect_ev(cyc + 9, 2'b00, 2'b10, 2'b01);
    step(12);

    noisy = 2'b11;
    step(6);
    chk("busy_mid_count", {7'd0, busy}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {debounced, rise, fall, 1'b0, busy}, 8'h00);
    step(3);
    reset = 1'b1;
    expect_ev(cyc + 7, 2'b11, 2'b00, 2'b11);
    step(10);

    chk("pending_events", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debouncer_multi_ch.md
Name: debouncer_multi_ch

Overview:
- Parametrised N-channel switch debouncer; successor to the single-channel delay-FSM debouncer.
- Each channel has its own input synchroniser, its own dwell counter and its own 4-state FSM. No external timer is needed.
- Press and release qualification times are separate, so release is filtered as well as press.
- Sits between raw board buttons/switches and the control logic. Provides level outputs and single-cycle edge strobes.

Parameters:
- N_CH, 4: number of independent channels.
- CNT_W, 20: dwell counter width per channel.
- PRESS_TICKS, 500000: qualifying ticks of stable-high input before the output asserts. Legal range 1..2^CNT_W-1.
- RELEASE_TICKS, 500000: qualifying ticks of stable-low input before the output deasserts. Legal range 1..2^CNT_W-1.
- SYNC_STAGES, 2: flops in each input synchroniser, >=2.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- tick_en, input, 1: counting strobe from a prescaler; tie to 1 to count clk cycles.
- clr, input, 1: synchronous soft clear of all channels.
- noisy, input, N_CH: raw asynchronous switch inputs.
- debounced, output, N_CH: filtered level per channel.
- rise, output, N_CH: one-cycle strobe when debounced goes 0->1.
- fall, output, N_CH: one-cycle strobe when debounced goes 1->0.
- busy, output, 1: OR over channels of "in a WAIT state".

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops = 0, counters = 0, all FSMs = LOW.
  - debounced, rise, fall and busy = 0.
  - Applies immediately, also mid-count; no strobe is emitted on reset entry or exit.
- Synchroniser: noisy[i] passes through SYNC_STAGES flops to give s[i]. The FSM sees only s[i].
- FSM per channel: states LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: if s=1, go to WAIT_HIGH and set cnt=0. Otherwise stay.
  - WAIT_HIGH:
    - if s=0, go to LOW (bounce rejected, no strobe);
    - else if tick_en=1 and cnt==PRESS_TICKS-1, go to HIGH;
    - else if tick_en=1, cnt+1;
    - else hold.
  - HIGH: if s=0, go to WAIT_LOW and set cnt=0. Otherwise stay.
  - WAIT_LOW:
    - if s=1, go to HIGH (release bounce rejected, no strobe);
    - else if tick_en=1 and cnt==RELEASE_TICKS-1, go to LOW;
    - else if tick_en=1, cnt+1;
    - else hold.
- Outputs:
  - debounced = 1 in HIGH and WAIT_LOW (registered from state).
  - busy = 1 if any channel is in WAIT_HIGH or WAIT_LOW.
  - rise/fall are registered: high exactly in the first cycle debounced shows its new value, and for one cycle only.
- Latency with tick_en=1: from the first clk edge sampling noisy high to debounced=1 is SYNC_STAGES+PRESS_TICKS+1 cycles. Release is symmetric with RELEASE_TICKS.
- The counter never wraps: it only increments below the terminal value, which is checked before the increment.
- tick_en=0 freezes all counters but not the transitions to LOW or HIGH caused by s.
- clr=1:
  - next edge forces every FSM to LOW, cnt=0 and debounced=0;
  - fall is asserted for channels that were debounced=1;
  - clr has priority over all other transitions;
  - synchronisers are not cleared;
  - a channel still held high re-qualifies from WAIT_HIGH after clr drops.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous strobes.
- Parameter violations (PRESS_TICKS=0, ticks >= 2^CNT_W, SYNC_STAGES<2) are flagged by an elaboration-time check.

Test Plan:
All tests use N_CH=2, CNT_W=4, PRESS_TICKS=4, RELEASE_TICKS=6, SYNC_STAGES=2, tick_en=1.
- Reset: hold reset=0 with noisy=2'b11 -> debounced=00, rise=fall=00 and busy=0 throughout. Release reset -> ch0/ch1 debounced=1 exactly 7 cycles later, rise=11 for one cycle.
- Clean press/release on ch0:
  - noisy[0] goes 0->1 -> debounced[0]=1 after 7 cycles, rise[0] pulses once.
  - noisy[0] goes 1->0 -> debounced[0]=0 after 9 cycles, fall[0] pulses once.
- Bounce rejection:
  - noisy[0] high for 3 cycles, low for 1, repeated 5 times -> debounced[0] stays 0 and no rise.
  - Same bounce pattern after qualification -> debounced[0] stays 1 and no fall.
- tick_en gating: tick_en toggles 1,0 every cycle during a press -> debounced[0] asserts after 2+2*4 cycles (±1). busy=1 while in WAIT_HIGH.
- clr mid-operation:
  - ch0 debounced=1 and ch1 in WAIT_HIGH, pulse clr for 1 cycle -> next cycle debounced=00, fall=01, ch1 cnt=0.
  - With noisy still 11, both re-qualify 5 cycles after clr drops.
- Async reset mid-count: drop reset while ch1 cnt=3 -> outputs go to 0 immediately with no clk edge, and no fall strobe.
